dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Sequences and shares the single data-memory (DM) port between two requesters.
- Requester 0 is the CPU MEM stage; requester 1 is an external bus master (debug/DMA bridge).
- Models a fixed-latency DM: one granted access holds the DM interface stable for WAIT_CYCLES cycles, then returns a registered response.
- Stalls the pipeline while the CPU access is outstanding.

Parameters:
- WAIT_CYCLES, 2, number of cycles DM control/address are held per access; legal range 1..15.
- CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU access request, level; held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data, already forwarded.
- cpu_be  in  4  byte enables.
- cpu_rdata  out  32  read data; valid when cpu_done = 1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  pipeline freeze, = cpu_req & ~cpu_done (combinational).
- ext_req, ext_we, ext_addr[31:0], ext_wdata[31:0], ext_be[3:0]  in  same meaning for the external master.
- ext_rdata  out  32  external read data; valid when ext_done = 1.
- ext_done  out  1  one-cycle completion pulse.
- ext_gnt  out  1  high while the external access owns the DM port (ACC or RESP with owner = EXT).
- dm_en  out  1  DM access active.
- dm_we  out  1  DM write strobe.
- dm_addr  out  32  DM address.
- dm_wdata  out  32  DM write data.
- dm_be  out  4  DM byte enables.
- dm_rdata  in  32  DM read data; valid during the final access cycle.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; counter = 0.
  - last_owner = EXT, so the CPU wins the first tie.
  - All outputs 0: done, rdata, gnt, all dm_* signals.
  - cpu_stall follows its combinational definition, so it equals cpu_req during reset.
- State machine, states IDLE / ACC / RESP, plus an owner register (CPU/EXT):
  - IDLE, no request: stay in IDLE.
  - IDLE, only one req high: grant that requester.
  - IDLE, both req high: grant the requester that is not last_owner (round-robin).
  - On a grant at the clock edge: latch we/addr/wdata/be from the winner; set owner and last_owner; counter = 0; go to ACC.
  - ACC: dm_en = 1 and dm_addr/dm_wdata/dm_be come from the latched values, stable for all WAIT_CYCLES cycles.
  - ACC, dm_we: equals latched we only when counter == WAIT_CYCLES-1, so a write happens exactly once, on the final cycle.
  - ACC, counter < WAIT_CYCLES-1: counter++.
  - ACC, counter == WAIT_CYCLES-1: capture dm_rdata into the owner's rdata register (reads only; writes leave rdata unchanged); go to RESP.
  - RESP: the owner's done = 1 for exactly one cycle; dm_en = 0; next state is IDLE.
- Latency: request seen at edge k → done high during cycle k+WAIT_CYCLES+1. Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Request protocol:
  - The requester must drop req by the edge that ends its done cycle.
  - A req still high in IDLE after that edge is a new access.
  - Changes to request inputs during ACC are ignored because values are latched at grant.
- The losing requester keeps waiting with no side effect. cpu_stall stays 1 while the CPU waits behind an EXT access.
- be = 0 write: full sequence runs with dm_we = 1 and dm_be = 0; no bytes change.
- Reset mid-ACC: access aborted immediately. If asserted before the final cycle, no DM write occurs. No done pulse is generated.
- rdata registers hold their value until the next read completion for the same requester.

Test Plan:
- Reset values: reset = 0 with both req high → all outputs 0, cpu_stall = 1. Release reset, WAIT_CYCLES = 2 → CPU granted at first edge; dm_en high for 2 cycles; cpu_done in the 3rd cycle after the grant edge.
- CPU read of addr 0x10, dm_rdata = 0xDEADBEEF on the final ACC cycle → cpu_rdata = 0xDEADBEEF with cpu_done = 1; dm_we = 0 throughout; cpu_stall drops in the done cycle.
- EXT write of 0x12345678 to 0x20 with be = 4'b0011 → dm_we high only on the final ACC cycle with dm_be = 0011; ext_gnt high in ACC and RESP; ext_done pulse 1 cycle.
- Both req continuously high → grants alternate CPU, EXT, CPU, EXT; each done pulse is separated by WAIT_CYCLES+2 = 4 cycles.
- reset asserted during the first ACC cycle of a CPU write → no dm_we pulse, no cpu_done; after release the held CPU req is re-granted and completes normally.
- WAIT_CYCLES = 1 build, back-to-back CPU reads with req re-asserted after each done → done every 3 cycles; dm_addr changes only at grant edges.

Source files
------------

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dm_port_arbiter
// Shares one fixed-latency data-memory port between the CPU and an external
// master with round-robin arbitration on ties.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_be,
  output logic [31:0] ext_rdata,
  output logic        ext_done,
  output logic        ext_gnt,
  output logic        dm_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic             C_CPU  = 1'b0;
  localparam logic             C_EXT  = 1'b1;

  state_t             r_state;
  logic               r_owner;
  logic               r_last_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_cpu_rdata;
  logic [31:0]        r_ext_rdata;
  logic               r_cpu_done;
  logic               r_ext_done;
  logic               r_ext_gnt;
  logic               r_dm_en;
  logic               r_dm_we;

  logic               w_pick_ext;
  logic               w_sel_we;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // On a tie the requester that did not own the port last time wins.
  assign w_pick_ext = ext_req & (~cpu_req | (r_last_owner == C_CPU));
  assign w_sel_we   = w_pick_ext ? ext_we : cpu_we;
  assign w_cnt_nxt  = r_cnt + C_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= C_CPU;
      r_last_owner <= C_EXT;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
      r_cpu_done   <= 1'b0;
      r_ext_done   <= 1'b0;
      r_ext_gnt    <= 1'b0;
      r_dm_en      <= 1'b0;
      r_dm_we      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req | ext_req) begin
            r_state      <= S_ACC;
            r_owner      <= w_pick_ext;
            r_last_owner <= w_pick_ext;
            r_cnt        <= '0;
            r_we         <= w_sel_we;
            r_addr       <= w_pick_ext ? ext_addr  : cpu_addr;
            r_wdata      <= w_pick_ext ? ext_wdata : cpu_wdata;
            r_be         <= w_pick_ext ? ext_be    : cpu_be;
            r_ext_gnt    <= w_pick_ext;
            r_dm_en      <= 1'b1;
            r_dm_we      <= (WAIT_CYCLES == 1) ? w_sel_we : 1'b0;
          end
        end
        S_ACC: begin
          if (r_cnt == C_LAST) begin
            r_state    <= S_RESP;
            r_dm_en    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_cpu_done <= (r_owner == C_CPU);
            r_ext_done <= (r_owner == C_EXT);
            if (!r_we) begin
              if (r_owner == C_EXT) r_ext_rdata <= dm_rdata;
              else                  r_cpu_rdata <= dm_rdata;
            end
          end else begin
            r_cnt   <= w_cnt_nxt;
            // The write strobe is raised only for the last access cycle.
            r_dm_we <= (w_cnt_nxt == C_LAST) & r_we;
          end
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_cpu_done <= 1'b0;
          r_ext_done <= 1'b0;
          r_ext_gnt  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_done  = r_cpu_done;
  assign cpu_stall = cpu_req & ~r_cpu_done;
  assign ext_rdata = r_ext_rdata;
  assign ext_done  = r_ext_done;
  assign ext_gnt   = r_ext_gnt;
  assign dm_en     = r_dm_en;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_addr;
  assign dm_wdata  = r_wdata;
  assign dm_be     = r_be;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_dm_port_arbiter
// Scoreboard bench for dm_port_arbiter (WAIT_CYCLES = 2 and 1 builds).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_dm_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [3:0]  cpu_be, ext_be;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        cpu_done, cpu_stall, ext_done, ext_gnt;
  logic        dm_en, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  logic        b_cpu_req;
  logic [31:0] b_cpu_addr;
  logic [31:0] b_cpu_rdata, b_ext_rdata;
  logic        b_cpu_done, b_cpu_stall, b_ext_done, b_ext_gnt;
  logic        b_dm_en, b_dm_we;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [3:0]  b_dm_be;

  dm_port_arbiter #(.WAIT_CYCLES(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_be(ext_be), .ext_rdata(ext_rdata), .ext_done(ext_done), .ext_gnt(ext_gnt),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata)
  );

  dm_port_arbiter #(.WAIT_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(b_cpu_addr), .cpu_wdata(32'h0),
    .cpu_be(4'hf), .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
    .ext_req(1'b0), .ext_we(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0),
    .ext_be(4'h0), .ext_rdata(b_ext_rdata), .ext_done(b_ext_done), .ext_gnt(b_ext_gnt),
    .dm_en(b_dm_en), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_be(b_dm_be), .dm_rdata(b_dm_rdata)
  );

  // Data-memory model: reads are combinational, writes land on the clock edge.
  logic [31:0] mem [0:255];
  int          n_wr = 0;
  int          cyc  = 0;

  assign dm_rdata   = dm_en   ? mem[dm_addr[9:2]]   : 32'h0;
  assign b_dm_rdata = b_dm_en ? mem[b_dm_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'hAABBCCDD;
      mem[12] <= 32'h00000000;
      mem[16] <= 32'h11110000;
      mem[17] <= 32'h22220001;
      mem[18] <= 32'h33330002;
    end else if (dm_we) begin
      n_wr <= n_wr + 1;
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          inst;
    int          who;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int inst, input int who, input logic [31:0] rd, input int c);
    exp_t e;
    e.inst  = inst;
    e.who   = who;
    e.rdata = rd;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic chk_done(input int inst, input int who, input logic [31:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_done", 32'(inst * 2 + who), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("done_inst",  32'(inst), 32'(e.inst));
      chk("done_who",   32'(who),  32'(e.who));
      chk("done_rdata", rd,        e.rdata);
      chk("done_cycle", 32'(cyc),  32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (cpu_done)   chk_done(0, 0, cpu_rdata);
    if (ext_done)   chk_done(0, 1, ext_rdata);
    if (b_cpu_done) chk_done(1, 0, b_cpu_rdata);
  end

  logic [31:0] d_exp [3];

  initial begin
    int g;
    d_exp[0] = 32'h11110000;
    d_exp[1] = 32'h22220001;
    d_exp[2] = 32'h33330002;

    reset     = 1'b0;
    cpu_req   = 1'b1;  cpu_we = 1'b0;  cpu_addr = 32'h10;  cpu_wdata = 32'h0;  cpu_be = 4'hf;
    ext_req   = 1'b1;  ext_we = 1'b1;  ext_addr = 32'h20;  ext_wdata = 32'h12345678;
    ext_be    = 4'b0011;
    b_cpu_req = 1'b0;  b_cpu_addr = 32'h0;

    // Reset state with both requests high.
    repeat (3) @(negedge clk);
    chk("rst_dm_en",     32'(dm_en),     32'h0);
    chk("rst_dm_we",     32'(dm_we),     32'h0);
    chk("rst_dm_addr",   dm_addr,        32'h0);
    chk("rst_dm_wdata",  dm_wdata,       32'h0);
    chk("rst_dm_be",     32'(dm_be),     32'h0);
    chk("rst_cpu_done",  32'(cpu_done),  32'h0);
    chk("rst_ext_done",  32'(ext_done),  32'h0);
    chk("rst_ext_gnt",   32'(ext_gnt),   32'h0);
    chk("rst_cpu_rdata", cpu_rdata,      32'h0);
    chk("rst_ext_rdata", ext_rdata,      32'h0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h1);

    // CPU read wins the first tie, then the EXT partial write follows.
    g = cyc + 1;
    push(0, 0, 32'hDEADBEEF, g + 2);
    push(0, 1, 32'h0,        g + 6);
    reset = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      chk("a_dm_en", 32'(dm_en),     32'(t < 2 || t == 4 || t == 5));
      chk("a_dm_we", 32'(dm_we),     32'(t == 5));
      chk("a_gnt",   32'(ext_gnt),   32'(t >= 4));
      chk("a_stall", 32'(cpu_stall), 32'(t < 2));
      chk("a_addr",  dm_addr,        (t < 4) ? 32'h10 : 32'h20);
      if (t == 4 || t == 5) begin
        chk("a_be",    32'(dm_be), 32'h3);
        chk("a_wdata", dm_wdata,   32'h12345678);
      end
      if (t == 2) cpu_req = 1'b0;
      if (t == 6) ext_req = 1'b0;
    end
    chk("a_mem", mem[8], 32'hAABB5678);

    // Both requesters held high: grants alternate CPU, EXT, CPU, EXT.
    @(negedge clk);
    cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 32'h10;
    ext_req = 1'b1;  ext_we = 1'b0;  ext_addr = 32'h20;
    g = cyc + 1;
    push(0, 0, 32'hDEADBEEF, g + 2);
    push(0, 1, 32'hAABB5678, g + 6);
    push(0, 0, 32'hDEADBEEF, g + 10);
    push(0, 1, 32'hAABB5678, g + 14);
    for (int t = 0; t <= 14; t++) begin
      @(negedge clk);
      chk("b_dm_en", 32'(dm_en),     32'((t % 4) < 2));
      chk("b_dm_we", 32'(dm_we),     32'h0);
      chk("b_gnt",   32'(ext_gnt),   32'((t % 8) >= 4 && (t % 8) <= 6));
      chk("b_stall", 32'(cpu_stall), 32'((t % 8) != 2));
      if (t == 14) begin
        cpu_req = 1'b0;
        ext_req = 1'b0;
      end
    end
    chk("b_nwr", 32'(n_wr), 32'h1);

    // Reset during the first ACC cycle of a CPU write aborts it.
    @(negedge clk);
    cpu_req = 1'b1;  cpu_we = 1'b1;  cpu_addr = 32'h30;  cpu_wdata = 32'h55555555;  cpu_be = 4'hf;
    @(negedge clk);
    chk("c_acc_en", 32'(dm_en), 32'h1);
    reset = 1'b0;
    #1;
    chk("c_abort_en",    32'(dm_en),     32'h0);
    chk("c_abort_stall", 32'(cpu_stall), 32'h1);
    @(negedge clk);
    chk("c_abort_we",   32'(dm_we),    32'h0);
    chk("c_abort_done", 32'(cpu_done), 32'h0);
    chk("c_abort_nwr",  32'(n_wr),     32'h1);
    g = cyc + 1;
    push(0, 0, 32'h0, g + 2);
    reset = 1'b1;
    for (int t = 0; t <= 2; t++) begin
      @(negedge clk);
      chk("c_dm_we", 32'(dm_we), 32'(t == 1));
      if (t == 2) cpu_req = 1'b0;
    end
    chk("c_nwr", 32'(n_wr),  32'h2);
    chk("c_mem", mem[12],    32'h55555555);

    // Single-cycle build: back-to-back CPU reads, one completion every 3 cycles.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      b_cpu_req  = 1'b1;
      b_cpu_addr = 32'h40 + 32'(4 * k);
      g = cyc + 1;
      push(1, 0, d_exp[k], g + 1);
      for (int t = 0; t <= 2; t++) begin
        @(negedge clk);
        chk("d_dm_en",   32'(b_dm_en), 32'(t == 0));
        chk("d_dm_we",   32'(b_dm_we), 32'h0);
        chk("d_dm_addr", b_dm_addr,    32'h40 + 32'(4 * k));
        if (t == 1) b_cpu_req = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
